sdram_write: RTL and testbench

//  Write path of the wishbone SDRAM slave. Pops 32-bit words from a first-word-fall-through

---
 rtl/sdram_write_if.sv | 53 +++++
 rtl/sdram_write.sv | 252 +++++++++++++++++++++++++
 tb/tb_sdram_write.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_write_if.sv
// sdram_write_if: signal bundle between the SDRAM controller, the write FIFO
// and the SDRAM write path. The slave modport is the write path itself; the
// master modport is the controller/FIFO side that drives it.
// Also holds the shared SDRAM command encodings, {RAS,CAS,WE}, active low.
// Optional feature macro: SDRAM_WRITE_MASK_EN adds the fifo_mask byte enables.

`ifndef SDRAM_CMD_NOP
`define SDRAM_CMD_NOP       3'b111
`define SDRAM_CMD_ACTIVE    3'b011
`define SDRAM_CMD_READ      3'b101
`define SDRAM_CMD_WRITE     3'b100
`define SDRAM_CMD_PRECHARGE 3'b010
`define SDRAM_CMD_REFRESH   3'b001
`endif

interface sdram_write_if;
  logic        en;
  logic [21:0] address;
  logic        ready;
  logic        auto_refresh;
  logic [31:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_rd;
`ifdef SDRAM_WRITE_MASK_EN
  logic [3:0]  fifo_mask;
`endif
  logic [2:0]  command;
  logic [11:0] addr;
  logic [1:0]  bank;
  logic [15:0] data_out;
  logic        data_oe;
  logic [1:0]  data_mask;

`ifdef SDRAM_WRITE_MASK_EN
  modport slave (
    input  en, address, auto_refresh, fifo_data, fifo_empty, fifo_mask,
    output ready, fifo_rd, command, addr, bank, data_out, data_oe, data_mask
  );
  modport master (
    output en, address, auto_refresh, fifo_data, fifo_empty, fifo_mask,
    input  ready, fifo_rd, command, addr, bank, data_out, data_oe, data_mask
  );
`else
  modport slave (
    input  en, address, auto_refresh, fifo_data, fifo_empty,
    output ready, fifo_rd, command, addr, bank, data_out, data_oe, data_mask
  );
  modport master (
    output en, address, auto_refresh, fifo_data, fifo_empty,
    input  ready, fifo_rd, command, addr, bank, data_out, data_oe, data_mask
  );
`endif
endinterface

// File: rtl/sdram_write.sv
// sdram_write: write path of the wishbone SDRAM slave.
// Pops 32-bit words from a first-word-fall-through FIFO and writes each one as
// two 16-bit beats (upper half first) into consecutive columns of an open row.
// Rows are opened with ACTIVE, closed with PRECHARGE when the burst stops or
// the column counter rolls over, and a refresh request seen mid-transfer is
// held until the row is closed and then served with AUTO REFRESH.
// All state changes happen on the falling edge of clk; rst is async, active low.
// Optional feature macro: SDRAM_WRITE_MASK_EN (per-byte write enables -> DQM).

module sdram_write #(
  parameter int unsigned T_RCD = 3,  // ACT -> WRITE
  parameter int unsigned T_WR  = 2,  // NOPs after the last beat before PRE
  parameter int unsigned T_RP  = 3,  // PRE -> next command
  parameter int unsigned T_RFC = 7   // AR -> next command
) (
  input  logic         clk,
  input  logic         rst,
  sdram_write_if.slave bus
);

  localparam int unsigned DLY_W = 4;
  localparam logic [DLY_W-1:0] DLY_ZERO = {DLY_W{1'b0}};
  localparam logic [DLY_W-1:0] DLY_ONE  = {{(DLY_W-1){1'b0}}, 1'b1};
  localparam logic [DLY_W-1:0] DLY_RCD  = DLY_W'(T_RCD - 1);
  localparam logic [DLY_W-1:0] DLY_WR   = DLY_W'(T_WR);
  localparam logic [DLY_W-1:0] DLY_RP   = DLY_W'(T_RP - 1);
  localparam logic [DLY_W-1:0] DLY_RFC  = DLY_W'(T_RFC - 1);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_ACTIVATE     = 3'd1,
    S_WRITE_TOP    = 3'd2,
    S_WRITE_BOTTOM = 3'd3,
    S_PRECHARGE    = 3'd4,
    S_REFRESH      = 3'd5,
    S_RESTART      = 3'd6
  } state_t;

  state_t           state_q,    state_d;
  logic [DLY_W-1:0] delay_q,    delay_d;
  logic [21:0]      laddr_q,    laddr_d;
  logic [31:0]      wdata_q,    wdata_d;
  logic             lref_q,     lref_d;
  logic [2:0]       command_q,  command_d;
  logic [11:0]      addr_q,     addr_d;
  logic [1:0]       bank_q,     bank_d;
  logic [15:0]      data_out_q, data_out_d;
  logic             data_oe_q,  data_oe_d;
  logic             fifo_rd_q,  fifo_rd_d;

  logic take_s;      // latch the FIFO head word and pop it this edge
  logic avail_s;     // a word is waiting and the controller grants the path
  logic cont_s;      // keep streaming within the open row
  logic beat_top_s;  // this edge drives the upper data beat
  logic beat_bot_s;  // this edge drives the lower data beat

  assign avail_s = bus.en & ~bus.fifo_empty;
  assign cont_s  = avail_s & ~lref_q;

  // Next-state and next-output computation for the write sequencer
  always_comb begin
    state_d    = state_q;
    delay_d    = delay_q;
    laddr_d    = laddr_q;
    wdata_d    = wdata_q;
    command_d  = `SDRAM_CMD_NOP;
    addr_d     = addr_q;
    bank_d     = bank_q;
    data_out_d = data_out_q;
    data_oe_d  = 1'b0;
    fifo_rd_d  = 1'b0;
    take_s     = 1'b0;
    beat_top_s = 1'b0;
    beat_bot_s = 1'b0;

    // A refresh request arriving while a transfer is in progress is parked
    // until the open row has been precharged.
    if (bus.auto_refresh && (state_q != S_IDLE)) begin
      lref_d = 1'b1;
    end else begin
      lref_d = lref_q;
    end

    if (delay_q != DLY_ZERO) begin
      delay_d = delay_q - DLY_ONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (avail_s) begin
            laddr_d = bus.address;
            take_s  = 1'b1;
            state_d = S_ACTIVATE;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_ACTIVATE: begin
          command_d = `SDRAM_CMD_ACTIVE;
          bank_d    = laddr_q[21:20];
          addr_d    = laddr_q[19:8];
          delay_d   = DLY_RCD;
          state_d   = S_WRITE_TOP;
        end

        S_WRITE_TOP: begin
          // A10 low: no auto-precharge, the row stays open for streaming.
          command_d  = `SDRAM_CMD_WRITE;
          addr_d     = {4'b0000, laddr_q[7:0]};
          data_out_d = wdata_q[31:16];
          data_oe_d  = 1'b1;
          beat_top_s = 1'b1;
          laddr_d    = laddr_q + 22'd2;
          state_d    = S_WRITE_BOTTOM;
        end

        S_WRITE_BOTTOM: begin
          data_out_d = wdata_q[15:0];
          data_oe_d  = 1'b1;
          beat_bot_s = 1'b1;
          // Column 0 after the increment means the row rolled over.
          if (cont_s && (laddr_q[7:0] != 8'h00)) begin
            take_s  = 1'b1;
            state_d = S_WRITE_TOP;
          end else begin
            delay_d = DLY_WR;
            state_d = S_PRECHARGE;
          end
        end

        S_PRECHARGE: begin
          // Bank stays at the row being closed, even if laddr moved banks.
          command_d = `SDRAM_CMD_PRECHARGE;
          addr_d    = 12'h000;
          delay_d   = DLY_RP;
          if (lref_q) begin
            state_d = S_REFRESH;
          end else if (avail_s) begin
            take_s  = 1'b1;
            state_d = S_ACTIVATE;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_REFRESH: begin
          command_d = `SDRAM_CMD_REFRESH;
          delay_d   = DLY_RFC;
          lref_d    = 1'b0;
          state_d   = S_RESTART;
        end

        S_RESTART: begin
          if (avail_s) begin
            take_s  = 1'b1;
            state_d = S_ACTIVATE;
          end else begin
            state_d = S_IDLE;
          end
        end

        default: begin
          command_d = `SDRAM_CMD_NOP;
          delay_d   = DLY_ZERO;
          state_d   = S_IDLE;
        end
      endcase
    end

    if (take_s) begin
      wdata_d   = bus.fifo_data;
      fifo_rd_d = 1'b1;
    end else begin
      wdata_d   = wdata_d;
      fifo_rd_d = fifo_rd_d;
    end
  end

  // Sequencer state and registered SDRAM/FIFO outputs, updated on the falling edge
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      delay_q    <= DLY_ZERO;
      laddr_q    <= 22'h000000;
      wdata_q    <= 32'h00000000;
      lref_q     <= 1'b0;
      command_q  <= `SDRAM_CMD_NOP;
      addr_q     <= 12'h000;
      bank_q     <= 2'b00;
      data_out_q <= 16'h0000;
      data_oe_q  <= 1'b0;
      fifo_rd_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      delay_q    <= delay_d;
      laddr_q    <= laddr_d;
      wdata_q    <= wdata_d;
      lref_q     <= lref_d;
      command_q  <= command_d;
      addr_q     <= addr_d;
      bank_q     <= bank_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      fifo_rd_q  <= fifo_rd_d;
    end
  end

`ifdef SDRAM_WRITE_MASK_EN
  logic [3:0] mask_q,      mask_d;
  logic [1:0] data_mask_q, data_mask_d;

  // Byte enables travel with the word; DQM is their inverse on each beat
  always_comb begin
    if (take_s) begin
      mask_d = bus.fifo_mask;
    end else begin
      mask_d = mask_q;
    end
    if (beat_top_s) begin
      data_mask_d = ~mask_q[3:2];
    end else if (beat_bot_s) begin
      data_mask_d = ~mask_q[1:0];
    end else begin
      data_mask_d = 2'b00;
    end
  end

  // Byte-enable latch and registered DQM
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      mask_q      <= 4'h0;
      data_mask_q <= 2'b00;
    end else begin
      mask_q      <= mask_d;
      data_mask_q <= data_mask_d;
    end
  end

  assign bus.data_mask = data_mask_q;
`else
  assign bus.data_mask = 2'b00;
`endif

  assign bus.ready    = (state_q == S_IDLE) && (delay_q == DLY_ZERO);
  assign bus.fifo_rd  = fifo_rd_q;
  assign bus.command  = command_q;
  assign bus.addr     = addr_q;
  assign bus.bank     = bank_q;
  assign bus.data_out = data_out_q;
  assign bus.data_oe  = data_oe_q;

endmodule

// File: tb/tb_sdram_write.sv
// tb_sdram_write: self-checking bench for sdram_write.
// The bench plays the write FIFO and watches the SDRAM bus. Every word the
// DUT pops goes onto a scoreboard together with the address the bench expects
// it at; each WRITE command pops the scoreboard and is checked against the
// row opened by the last ACTIVE, the column, both data beats and DQM.
// A table of transfer scenarios drives the bulk; reset, exact timing of a
// single word, an idle grant with an empty FIFO and reset mid-write are
// hand-written sequences. Honours SDRAM_WRITE_MASK_EN.

module tb_sdram_write;

  localparam logic [2:0] C_NOP = 3'b111;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_AR  = 3'b001;
`ifdef SDRAM_WRITE_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  sdram_write_if bus ();

  sdram_write dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { logic [31:0] d; logic [3:0] m; } fw_t;
  typedef struct { logic [21:0] a; logic [31:0] d; logic [3:0] m; } wr_t;
  typedef struct {
    logic [21:0] addr;
    int          nwords;
    logic [31:0] d0;
    int          refresh_at;  // cycle of the 1-cycle auto_refresh pulse, -1 none
    int          en_drop_at;  // cycle en goes low, -1 never
    int          exp_act;
    int          exp_pre;
    int          exp_ar;
    int          exp_rd;
  } vec_t;

  fw_t         fifo_q[$];
  wr_t         sb[$];
  wr_t         cur;
  logic [21:0] exp_addr;
  int          n_pass, n_total, cyc;
  int          n_act, n_pre, n_ar, n_rd;
  int          act_cyc, wr_cyc, pre_cyc, rise_cyc;
  bit          pend_bot, since_act, bank_open, ready_prev;
  logic [1:0]  open_bank;
  logic [11:0] open_row;
  vec_t        vecs[8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [1:0] exp_dm(input logic [3:0] m, input bit top);
    logic [1:0] v;
    v = top ? ~m[3:2] : ~m[1:0];
    return MASK_EN ? v : 2'b00;
  endfunction

  // One clock: sample the SDRAM bus at the rising edge (DUT moves on falling),
  // check it, service a FIFO pop and present the new FIFO head.
  task automatic tick();
    fw_t e;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      pend_bot  = 1'b0;
      bank_open = 1'b0;
      since_act = 1'b1;
    end else begin
      if (pend_bot) begin
        check("bot_cmd", 32'(bus.command), 32'(C_NOP));
        check("bot_oe", 32'(bus.data_oe), 32'd1);
        check("bot_data", 32'(bus.data_out), 32'(cur.d[15:0]));
        check("bot_dqm", 32'(bus.data_mask), 32'(exp_dm(cur.m, 1'b0)));
        pend_bot = 1'b0;
      end else if (bus.command != C_WR) begin
        check("oe_idle", 32'(bus.data_oe), 32'd0);
      end
      case (bus.command)
        C_NOP: ;
        C_ACT: begin
          check("act_bank_closed", 32'(bank_open), 32'd0);
          n_act++;
          open_bank = bus.bank;
          open_row  = bus.addr;
          bank_open = 1'b1;
          since_act = 1'b1;
          act_cyc   = cyc;
        end
        C_WR: begin
          check("wr_oe", 32'(bus.data_oe), 32'd1);
          check("wr_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            cur = sb.pop_front();
            check("wr_row_open", 32'(bank_open), 32'd1);
            check("wr_bank", 32'(bus.bank), 32'(cur.a[21:20]));
            check("wr_act_bank", 32'(open_bank), 32'(cur.a[21:20]));
            check("wr_row", 32'(open_row), 32'(cur.a[19:8]));
            check("wr_col", 32'(bus.addr), 32'({4'b0000, cur.a[7:0]}));
            check("wr_top", 32'(bus.data_out), 32'(cur.d[31:16]));
            check("wr_dqm_top", 32'(bus.data_mask), 32'(exp_dm(cur.m, 1'b1)));
            pend_bot = 1'b1;
          end
          if (!since_act) check("wr_gap", 32'(cyc - wr_cyc), 32'd2);
          since_act = 1'b0;
          wr_cyc    = cyc;
        end
        C_PRE: begin
          n_pre++;
          check("pre_bank", 32'(bus.bank), 32'(open_bank));
          check("pre_addr", 32'(bus.addr), 32'd0);
          bank_open = 1'b0;
          pre_cyc   = cyc;
        end
        C_AR: begin
          n_ar++;
          check("ar_bank_closed", 32'(bank_open), 32'd0);
        end
        default: check("cmd_legal", 32'(bus.command), 32'(C_NOP));
      endcase
      if (bus.ready && !ready_prev) rise_cyc = cyc;
      ready_prev = bus.ready;
    end
    if (bus.fifo_rd) begin
      n_rd++;
      check("pop_nonempty", 32'(fifo_q.size() != 0), 32'd1);
      if (fifo_q.size() != 0) begin
        e = fifo_q.pop_front();
        sb.push_back('{exp_addr, e.d, e.m});
        exp_addr = exp_addr + 22'd2;
      end
    end
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_data  = (fifo_q.size() == 0) ? 32'h0 : fifo_q[0].d;
`ifdef SDRAM_WRITE_MASK_EN
    bus.fifo_mask  = (fifo_q.size() == 0) ? 4'h0 : fifo_q[0].m;
`endif
  endtask

  task automatic load(input logic [21:0] a, input int n, input logic [31:0] d0);
    fw_t w;
    exp_addr = a;
    for (int i = 0; i < n; i++) begin
      w.d = d0 + (32'(i) * 32'h0101_0101);
      w.m = (i == 0) ? 4'b0110 : 4'($urandom_range(0, 15));
      fifo_q.push_back(w);
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit done;
    n_act = 0; n_pre = 0; n_ar = 0; n_rd = 0;
    load(v.addr, v.nwords, v.d0);
    tick();
    bus.address = v.addr;
    bus.en      = 1'b1;
    done = 1'b0;
    for (int c = 1; c <= 400 && !done; c++) begin
      tick();
      bus.auto_refresh = (c == v.refresh_at);
      if (v.en_drop_at >= 0 && c >= v.en_drop_at) bus.en = 1'b0;
      if (c > 2 && bus.ready && sb.size() == 0 && !pend_bot) done = 1'b1;
    end
    bus.en = 1'b0;
    bus.auto_refresh = 1'b0;
    check("done", 32'(done), 32'd1);
    check("n_act", 32'(n_act), 32'(v.exp_act));
    check("n_pre", 32'(n_pre), 32'(v.exp_pre));
    check("n_ar", 32'(n_ar), 32'(v.exp_ar));
    check("n_fifo_rd", 32'(n_rd), 32'(v.exp_rd));
    fifo_q.delete();
  endtask

  initial begin
    bit seen;
    vec_t t1;
    n_pass = 0; n_total = 0; cyc = 0;
    n_act = 0; n_pre = 0; n_ar = 0; n_rd = 0;
    act_cyc = 0; wr_cyc = 0; pre_cyc = 0; rise_cyc = 0;
    pend_bot = 1'b0; since_act = 1'b1; bank_open = 1'b0; ready_prev = 1'b1;
    open_bank = 2'b00; open_row = 12'h000; exp_addr = 22'h0;
    cur = '{22'h0, 32'h0, 4'h0};
    rst = 1'b0;
    bus.en = 1'b0; bus.address = 22'h0; bus.auto_refresh = 1'b0;
    bus.fifo_data = 32'h0; bus.fifo_empty = 1'b1;
`ifdef SDRAM_WRITE_MASK_EN
    bus.fifo_mask = 4'h0;
`endif

    //                addr     n  d0            ref drop act pre ar rd
    vecs[0] = '{22'h000010, 4, 32'h1122_3344, -1, -1, 1, 1, 0, 4};
    vecs[1] = '{22'h0123FE, 2, 32'hA5A5_0F0F, -1, -1, 2, 2, 0, 2};
    vecs[2] = '{22'h3FFFFE, 2, 32'hCAFE_F00D, -1, -1, 2, 2, 0, 2};
    vecs[3] = '{22'h000100, 4, 32'h0BAD_C0DE,  6, -1, 2, 2, 1, 4};
    vecs[4] = '{22'h000020, 2, 32'h5555_AAAA, -1, -1, 1, 1, 0, 2};
    vecs[5] = '{22'h000024, 2, 32'h7E7E_8181, -1, -1, 1, 1, 0, 2};
    vecs[6] = '{22'h000200, 4, 32'h1357_9BDF, -1,  3, 1, 1, 0, 1};
    vecs[7] = '{22'h1000F8, 6, 32'h0246_8ACE, -1, -1, 2, 2, 0, 6};

    // reset state
    tick(); tick();
    check("rst_cmd", 32'(bus.command), 32'(C_NOP));
    check("rst_addr", 32'(bus.addr), 32'd0);
    check("rst_bank", 32'(bus.bank), 32'd0);
    check("rst_data", 32'(bus.data_out), 32'd0);
    check("rst_oe", 32'(bus.data_oe), 32'd0);
    check("rst_dqm", 32'(bus.data_mask), 32'd0);
    check("rst_fifo_rd", 32'(bus.fifo_rd), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd1);
    rst = 1'b1;
    tick(); tick();

    // single word: exact command spacing
    t1 = '{22'h012344, 1, 32'hDEAD_BEEF, -1, -1, 1, 1, 0, 1};
    run_vec(t1);
    check("t1_act_to_wr", 32'(wr_cyc - act_cyc), 32'd3);
    check("t1_wr_to_pre", 32'(pre_cyc - wr_cyc), 32'd4);
    check("t1_pre_to_ready", 32'(rise_cyc - pre_cyc), 32'd2);
    check("t1_row", 32'(open_row), 32'h123);

    foreach (vecs[i]) run_vec(vecs[i]);

    // grant held with an empty FIFO: no pops, no commands, stays ready
    n_act = 0; n_rd = 0;
    bus.en = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("empty_no_rd", 32'(n_rd), 32'd0);
    check("empty_no_act", 32'(n_act), 32'd0);
    check("empty_ready", 32'(bus.ready), 32'd1);
    bus.en = 1'b0;

    // reset asserted while a WRITE is on the bus
    load(22'h000300, 2, 32'h9999_6666);
    tick();
    bus.address = 22'h000300;
    bus.en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (bus.command == C_WR) seen = 1'b1;
    end
    check("rst_wait_write", 32'(seen), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_mid_cmd", 32'(bus.command), 32'(C_NOP));
    check("rst_mid_oe", 32'(bus.data_oe), 32'd0);
    check("rst_mid_rd", 32'(bus.fifo_rd), 32'd0);
    check("rst_mid_ready", 32'(bus.ready), 32'd1);
    bus.en = 1'b0;
    fifo_q.delete();
    sb.delete();
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    check("rst_after_cmd", 32'(bus.command), 32'(C_NOP));
    t1 = '{22'h000400, 2, 32'h0F1E_2D3C, -1, -1, 1, 1, 0, 2};
    run_vec(t1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
